mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath (single memory, single ALU, register file, PC/IR registers) through fetch, decode and execute steps.
- Decodes op/funct into per-state control strobes and embeds the ALU-decode mapping, so it drives alucontrol directly.
- Counts retired instructions for bring-up and debug.
- Sits between the IR/zero flag and every datapath enable/mux select.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- pcen  output  1  PC write enable
- irwrite  output  1  instruction register load
- memwrite  output  1  memory write strobe
- regwrite  output  1  register file write
- iord  output  1  memory address select (0 = PC, 1 = ALUOut)
- memtoreg  output  1  writeback select (1 = memory data)
- regdst  output  1  destination select (1 = rd, 0 = rt)
- alusrca  output  1  ALU A select (0 = PC, 1 = regA)
- alusrcb  output  2  ALU B select (00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2)
- pcsrc  output  2  next-PC select (00 = ALU, 01 = ALUOut, 10 = jump target)
- alucontrol  output  3  ALU function
- illegal_op  output  1  one-cycle pulse for an unsupported opcode
- state  output  4  current state (debug)
- instret  output  CNT_W  retired-instruction count

Behaviour:
- Registered state only; all strobes are combinational from state plus op/funct/zero.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12-15 go to FETCH.
- Reset:
  - While reset=1, all strobes are forced 0 and illegal_op=0.
  - The state register loads FETCH and instret loads 0 at the clock edge.
  - Reset asserted mid-instruction aborts it: no write, no count.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 100011 lw and 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other op -> FETCH with illegal_op=1 for that DECODE cycle
  - MEMADR->MEMRD if lw, else MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP each -> FETCH.
- Outputs per state (every unlisted output is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). zero is sampled combinationally in BRANCH only.
- alucontrol from the internal aluop:
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Any other funct under aluop 10 -> 010.
- instret increments by 1 on each clock edge that leaves MEMWB, MEMWR, ALUWB, BRANCH (taken or not), ADDIWB or JUMP. It wraps modulo 2^CNT_W. Illegal opcodes do not count.
- Cycles per instruction: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.

Test Plan:
- Reset for 2 cycles, then release with op=100011 -> cycles FETCH, DECODE, MEMADR, MEMRD, MEMWB:
  - state sequence 0, 1, 2, 3, 4
  - regwrite=1 and memtoreg=1 only in MEMWB
  - instret=1 after the 5th edge
- R-type op=000000, funct=101010 -> state sequence 0, 1, 6, 7; alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB; instret increments.
- beq op=000100:
  - zero=1 -> pcen=1 and pcsrc=01 in BRANCH
  - repeat with zero=0 -> pcen=0
  - both cases return to FETCH after 3 cycles and count.
- Illegal op=111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, instret unchanged. Follow with j (000010) -> JUMP state has pcwrite, so pcen=1 and pcsrc=10.
- Assert reset during MEMWR of a sw (op=101011) -> memwrite=0 in that cycle, state=0 after the edge, instret=0.
- Force instret to all-ones (CNT_W=4, 15 retirements), then retire one more -> instret=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath,
// with embedded ALU decode and a retired-instruction counter.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_pcwrite;
    logic             w_branch;
    logic [1:0]       w_aluop;
    logic             w_retire;

    // Every state whose exit completes an instruction; illegal opcodes leave from DECODE.
    assign w_retire = (r_state == S_MEMWB)  || (r_state == S_MEMWR) ||
                      (r_state == S_ALUWB)  || (r_state == S_BRANCH) ||
                      (r_state == S_ADDIWB) || (r_state == S_JUMP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset wins over the count so an aborted
    // instruction never retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_ONE;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a latch behind.
    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        illegal_op = 1'b0;

        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    irwrite   = 1'b1;
                    w_pcwrite = 1'b1;
                    alusrcb   = 2'b01;
                    w_next    = S_DECODE;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_EXECUTE;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_ADDI:      w_next = S_ADDIEX;
                        OP_J:         w_next = S_JUMP;
                        default: begin
                            w_next     = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    iord   = 1'b1;
                    w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    w_aluop = 2'b10;
                    w_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca  = 1'b1;
                    w_aluop  = 2'b01;
                    pcsrc    = 2'b01;
                    w_branch = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_JUMP: begin
                    pcsrc     = 2'b10;
                    w_pcwrite = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    assign pcen    = w_pcwrite | (w_branch & zero);
    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_mc_controller;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             pcen;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op),
        .state      (state),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [3:0]       st;
        logic [15:0]      ctl;
        bit               chk_alu;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic [15:0]      w_act;

    // Control word: {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal_op}
    function automatic logic [15:0] mk(bit pc, bit irw, bit mw, bit rw, bit ido, bit m2r, bit rd,
                                       bit asa, logic [1:0] asb, logic [1:0] pcs,
                                       logic [2:0] aluc, bit ill);
        return {pc, irw, mw, rw, ido, m2r, rd, asa, asb, pcs, aluc, ill};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            w_act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
                     alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
            if (!mon_e.chk_alu) begin
                w_act[3:1] = mon_e.ctl[3:1];
            end
            check({mon_e.nm, ".state"}, 32'(state), 32'(mon_e.st));
            check({mon_e.nm, ".ctl"}, 32'(w_act), 32'(mon_e.ctl));
            check({mon_e.nm, ".instret"}, 32'(instret), 32'(mon_e.cnt));
        end
    end

    // Queue one cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [3:0] st, input logic [15:0] ctl, input bit chk_alu);
        exp_t e;
        e.nm      = nm;
        e.st      = st;
        e.ctl     = ctl;
        e.chk_alu = chk_alu;
        e.cnt     = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string nm, input logic [5:0] o, input logic [5:0] f, input bit z);
        op    = o;
        funct = f;
        zero  = z;
        cyc({nm, ".fetch"},  4'd0, mk(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0), 1);
        cyc({nm, ".decode"}, 4'd1, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0), 1);
    endtask

    task automatic run_lw();
        fetch_decode("lw", 6'b100011, 6'b000000, 1'b0);
        cyc("lw.memadr", 4'd2, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1);
        cyc("lw.memrd",  4'd3, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0), 1);
        cyc("lw.memwb",  4'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0), 1);
        exp_cnt++;
    endtask

    task automatic run_sw();
        fetch_decode("sw", 6'b101011, 6'b000000, 1'b0);
        cyc("sw.memadr", 4'd2, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1);
        cyc("sw.memwr",  4'd5, mk(0,0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0), 1);
        exp_cnt++;
    endtask

    task automatic run_r(input logic [5:0] f, input logic [2:0] aluc);
        fetch_decode("rtype", 6'b000000, f, 1'b0);
        cyc("rtype.execute", 4'd6, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,aluc,0), 1);
        cyc("rtype.aluwb",   4'd7, mk(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0), 1);
        exp_cnt++;
    endtask

    task automatic run_beq(input bit z);
        fetch_decode("beq", 6'b000100, 6'b000000, z);
        cyc("beq.branch", 4'd8, mk(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), 1);
        exp_cnt++;
    endtask

    task automatic run_addi();
        fetch_decode("addi", 6'b001000, 6'b000000, 1'b0);
        cyc("addi.ex", 4'd9,  mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1);
        cyc("addi.wb", 4'd10, mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010,0), 1);
        exp_cnt++;
    endtask

    task automatic run_j();
        fetch_decode("j", 6'b000010, 6'b000000, 1'b0);
        cyc("j.jump", 4'd11, mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0), 1);
        exp_cnt++;
    endtask

    task automatic run_illegal();
        op = 6'b111111;
        cyc("ill.fetch",  4'd0, mk(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0), 1);
        cyc("ill.decode", 4'd1, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1), 1);
    endtask

    initial begin
        exp_cnt = '0;
        reset   = 1'b1;
        op      = 6'b100011;
        funct   = 6'b000000;
        zero    = 1'b0;

        // First cycle: state is not yet defined before the first reset edge.
        @(posedge clk);
        #1;
        cyc("reset", 4'd0, 16'h0000, 0);
        reset = 1'b0;

        run_lw();
        run_r(6'b101010, 3'b111);
        run_beq(1'b1);
        run_beq(1'b0);
        run_illegal();
        run_j();
        run_addi();
        run_sw();
        run_r(6'b100000, 3'b010);
        run_r(6'b100010, 3'b110);
        run_r(6'b100100, 3'b000);
        run_r(6'b100101, 3'b001);
        run_r(6'b111111, 3'b010);

        // Abort a store in MEMWR: no write strobe, no retirement.
        fetch_decode("swrst", 6'b101011, 6'b000000, 1'b0);
        cyc("swrst.memadr", 4'd2, mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0), 1);
        reset = 1'b1;
        cyc("swrst.memwr", 4'd5, 16'h0000, 0);
        exp_cnt = '0;
        cyc("swrst.after", 4'd0, 16'h0000, 0);
        reset = 1'b0;

        // 15 retirements bring the 4-bit counter to all-ones, the 16th wraps it.
        for (int i = 0; i < 15; i++) begin
            run_j();
        end
        run_j();
        cyc("wrap.fetch", 4'd0, mk(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0), 1);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
